// File: rtl/rx_frame_controller.sv
// rx_frame_controller: hunts for SYNC, collects a length-prefixed payload from the UART byte
// receiver and drains it over valid/ready. Define RX_FRAME_CHECKSUM_EN to require a trailing sum byte.
module rx_frame_controller #(
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] SYNC    = 8'hAA
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_Done_Sig,
  input  logic [7:0] RX_Data,
  output logic       RX_En_Sig,
  output logic [7:0] Frame_Data,
  output logic       Frame_Valid,
  output logic       Frame_Last,
  input  logic       Frame_Ready,
  output logic       Err_Sig,
  output logic [1:0] Err_Code
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
`ifdef RX_FRAME_CHECKSUM_EN
    CSUM,
`endif
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    rd_q, rd_d, rd_next;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          in_frame;
  logic [7:0]    payload_buf [MAX_LEN];
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  assign rd_next  = rd_q + 8'd1;
  assign in_frame = (state_q != HUNT) && (state_q != DRAIN);

  assign RX_En_Sig   = (state_q != DRAIN);
  assign Frame_Valid = (state_q == DRAIN);
  assign Frame_Last  = Frame_Valid && (rd_q == len_q - 8'd1);
  assign Frame_Data  = data_q;
  assign Err_Sig     = err_q;
  assign Err_Code    = code_q;

  // Frame_Data is preloaded on entry to DRAIN so Valid and the first byte appear together.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = 1'b0;
    code_d  = code_q;
`ifdef RX_FRAME_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    tmo_d   = (RX_Done_Sig || !in_frame) ? '0 : tmo_q + TW'(1);

    case (state_q)
      HUNT: begin
        if (RX_Done_Sig && RX_Data == SYNC) state_d = LEN;
      end
      LEN: begin
        if (RX_Done_Sig) begin
          if (RX_Data == 8'd0 || RX_Data > MAX_LEN_B) begin
            state_d = HUNT;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end else begin
            len_d   = RX_Data;
            idx_d   = 8'd0;
`ifdef RX_FRAME_CHECKSUM_EN
            sum_d   = RX_Data;
`endif
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (RX_Done_Sig) begin
          idx_d = idx_q + 8'd1;
`ifdef RX_FRAME_CHECKSUM_EN
          sum_d = sum_q + RX_Data;
          if (idx_q == len_q - 8'd1) state_d = CSUM;
`else
          // A one-byte frame is still being written to the buffer, so bypass it.
          if (idx_q == len_q - 8'd1) begin
            state_d = DRAIN;
            rd_d    = 8'd0;
            data_d  = (idx_q == 8'd0) ? RX_Data : payload_buf[0];
          end
`endif
        end
      end
`ifdef RX_FRAME_CHECKSUM_EN
      CSUM: begin
        if (RX_Done_Sig) begin
          if (RX_Data == sum_q) begin
            state_d = DRAIN;
            rd_d    = 8'd0;
            data_d  = payload_buf[0];
          end else begin
            state_d = HUNT;
            err_d   = 1'b1;
            code_d  = 2'd2;
          end
        end
      end
`endif
      DRAIN: begin
        if (Frame_Ready) begin
          if (Frame_Last) begin
            state_d = HUNT;
          end else begin
            rd_d   = rd_next;
            data_d = payload_buf[rd_next[AW-1:0]];
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // A byte arriving on the expiry cycle keeps the frame alive.
    if (in_frame && !RX_Done_Sig && tmo_q == TMO_LAST) begin
      state_d = HUNT;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= HUNT;
      len_q   <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

`ifdef RX_FRAME_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) sum_q <= '0;
    else       sum_q <= sum_d;
  end
`endif

  always_ff @(posedge CLK) begin
    if (state_q == PAYLOAD && RX_Done_Sig) payload_buf[idx_q[AW-1:0]] <= RX_Data;
  end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: frame-level reference model compared every cycle,
// plus literal expectations per directed scenario. Honors RX_FRAME_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_rx_frame_controller;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 20;
  localparam int         GAP     = 3;
  localparam logic [7:0] SYNC    = 8'hAA;
`ifdef RX_FRAME_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       RX_Done_Sig = 1'b0;
  logic [7:0] RX_Data = 8'h00;
  logic       Frame_Ready = 1'b1;
  logic       RX_En_Sig, Frame_Valid, Frame_Last, Err_Sig;
  logic [7:0] Frame_Data;
  logic [1:0] Err_Code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cyc = 0;

  logic [7:0] got[$];
  logic [7:0] lasts[$];
  logic [7:0] errs[$];

  rx_frame_controller #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .SYNC(SYNC)) dut (
    .CLK(CLK), .RSTn(RSTn), .RX_Done_Sig(RX_Done_Sig), .RX_Data(RX_Data),
    .RX_En_Sig(RX_En_Sig), .Frame_Data(Frame_Data), .Frame_Valid(Frame_Valid),
    .Frame_Last(Frame_Last), .Frame_Ready(Frame_Ready), .Err_Sig(Err_Sig), .Err_Code(Err_Code)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] have, input logic [31:0] want);
    checks++;
    if (have !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h at %0t", name, have, want, $time);
    end
  endtask

  task automatic check_queue(input string name, input logic [7:0] have[$], input logic [7:0] want[$]);
    check_output({name, "_count"}, have.size(), want.size());
    foreach (want[i]) if (i < have.size()) check_output(name, have[i], want[i]);
  endtask

  // Reference model: what the frame rules say should be visible after each clock edge.
  typedef enum int {M_HUNT, M_LEN, M_PAY, M_CSUM, M_DRAIN} mode_t;
  mode_t      m_mode = M_HUNT;
  logic [7:0] m_pay[$];
  int         m_need = 0, m_pos = 0, m_silence = 0, m_done_cyc = 0;
  logic [7:0] m_sum = 8'h00;
  logic       m_err = 1'b0;
  logic [1:0] m_code = 2'd0;

  initial begin
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) begin
        m_mode = M_HUNT; m_pay.delete(); m_pos = 0; m_silence = 0;
        m_err = 1'b0; m_code = 2'd0;
      end else begin
        cyc++;
        m_err = 1'b0;
        if (RX_Done_Sig) m_done_cyc = cyc;
        if (m_mode inside {M_LEN, M_PAY, M_CSUM}) m_silence = RX_Done_Sig ? 0 : m_silence + 1;
        if (m_mode inside {M_LEN, M_PAY, M_CSUM} && m_silence == TIMEOUT) begin
          m_mode = M_HUNT; m_err = 1'b1; m_code = 2'd3;
        end else begin
          case (m_mode)
            M_HUNT: if (RX_Done_Sig && RX_Data == SYNC) begin m_mode = M_LEN; m_silence = 0; end
            M_LEN: if (RX_Done_Sig) begin
              if (RX_Data == 0 || int'(RX_Data) > MAX_LEN) begin
                m_mode = M_HUNT; m_err = 1'b1; m_code = 2'd1;
              end else begin
                m_need = RX_Data; m_sum = RX_Data; m_pay.delete(); m_mode = M_PAY;
              end
            end
            M_PAY: if (RX_Done_Sig) begin
              m_pay.push_back(RX_Data);
              m_sum = m_sum + RX_Data;
              if (m_pay.size() == m_need) begin
                m_mode = CSUM_ON ? M_CSUM : M_DRAIN;
                m_pos = 0;
              end
            end
            M_CSUM: if (RX_Done_Sig) begin
              if (RX_Data == m_sum) begin m_mode = M_DRAIN; m_pos = 0; end
              else begin m_mode = M_HUNT; m_err = 1'b1; m_code = 2'd2; end
            end
            M_DRAIN: if (Frame_Ready) begin
              if (m_pos == m_need - 1) m_mode = M_HUNT;
              else m_pos++;
            end
            default: m_mode = M_HUNT;
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge CLK);
      if (RSTn) begin
        check_output("rx_en", RX_En_Sig, m_mode != M_DRAIN);
        check_output("valid", Frame_Valid, m_mode == M_DRAIN);
        check_output("err_sig", Err_Sig, m_err);
        check_output("err_code", Err_Code, m_code);
        if (m_mode == M_DRAIN && Frame_Valid) begin
          check_output("data", Frame_Data, m_pay[m_pos]);
          check_output("last", Frame_Last, m_pos == m_need - 1);
          if (Frame_Ready) begin
            got.push_back(Frame_Data);
            lasts.push_back(8'(Frame_Last));
          end
        end
        if (prev_stall && Frame_Valid) check_output("stall_hold", Frame_Data, prev_data);
        prev_stall = Frame_Valid && !Frame_Ready;
        prev_data  = Frame_Data;
        if (Err_Sig) begin
          errs.push_back(8'(Err_Code));
          err_cyc = cyc;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_Data = b;
    RX_Done_Sig = 1'b1;
    tick();
    RX_Done_Sig = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (i < bytes.size() - 1) repeat (GAP) tick();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_mode != M_HUNT && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait frame still open after %0d cycles", n);
    end
    repeat (3) tick();
  endtask

  task automatic clear_logs();
    got.delete();
    lasts.delete();
    errs.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rx_en"}, RX_En_Sig, 1);
    check_output({tag, "_valid"}, Frame_Valid, 0);
    check_output({tag, "_last"}, Frame_Last, 0);
    check_output({tag, "_data"}, Frame_Data, 0);
    check_output({tag, "_err"}, Err_Sig, 0);
    check_output({tag, "_code"}, Err_Code, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] stim[$];
    logic [7:0] want[$];
    logic [7:0] none[$];

    #2;
    check_reset_values("reset");
    repeat (2) tick();
    RSTn = 1'b1;
    repeat (2) tick();

    // Good frame, back-to-back drain
    clear_logs();
    stim = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    apply_stimulus(stim);
    wait_idle();
    want = '{8'h11, 8'h22, 8'h33};
    check_queue("t1_bytes", got, want);
    want = '{8'h00, 8'h00, 8'h01};
    check_queue("t1_last", lasts, want);
    check_queue("t1_errs", errs, none);

    // Corrupt checksum, then a one-byte frame
    clear_logs();
    stim = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    apply_stimulus(stim);
    wait_idle();
`ifdef RX_FRAME_CHECKSUM_EN
    want = '{8'h02};
    check_queue("t2_errs", errs, want);
    check_queue("t2_bytes", got, none);
    check_output("t2_code", Err_Code, 2);
`else
    want = '{8'h11, 8'h22, 8'h33};
    check_queue("t2_bytes", got, want);
    check_queue("t2_errs", errs, none);
`endif
    clear_logs();
    stim = '{8'hAA, 8'h01, 8'h55, 8'h56};
    apply_stimulus(stim);
    wait_idle();
    want = '{8'h55};
    check_queue("t2b_bytes", got, want);

    // Bad lengths, leading junk, SYNC as payload
    clear_logs();
    stim = '{8'hAA, 8'h00, 8'hAA, 8'h11, 8'h55, 8'hAA, 8'h01, 8'hAA, 8'hAB};
    apply_stimulus(stim);
    wait_idle();
    want = '{8'h01, 8'h01};
    check_queue("t3_errs", errs, want);
    check_output("t3_code", Err_Code, 1);
    want = '{8'hAA};
    check_queue("t3_bytes", got, want);

    // Inter-byte timeout
    clear_logs();
    stim = '{8'hAA, 8'h02, 8'h10};
    apply_stimulus(stim);
    wait_idle();
    want = '{8'h03};
    check_queue("t4_errs", errs, want);
    check_output("t4_tmo_delay", err_cyc - m_done_cyc, TIMEOUT);
    check_queue("t4_bytes", got, none);

    // Byte lands exactly on the expiry cycle
    clear_logs();
    stim = '{8'hAA, 8'h02, 8'h10};
    apply_stimulus(stim);
    repeat (TIMEOUT - 1) tick();
`ifdef RX_FRAME_CHECKSUM_EN
    stim = '{8'h20, 8'h32};
`else
    stim = '{8'h20};
`endif
    apply_stimulus(stim);
    wait_idle();
    check_queue("t4b_errs", errs, none);
    want = '{8'h10, 8'h20};
    check_queue("t4b_bytes", got, want);

    // Drain with downstream back-pressure
    clear_logs();
`ifdef RX_FRAME_CHECKSUM_EN
    stim = '{8'hAA, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h19};
`else
    stim = '{8'hAA, 8'h03, 8'hA1, 8'hB2, 8'hC3};
`endif
    apply_stimulus(stim);
    want = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
    foreach (want[i]) begin
      Frame_Ready = want[i][0];
      tick();
    end
    Frame_Ready = 1'b1;
    wait_idle();
    want = '{8'hA1, 8'hB2, 8'hC3};
    check_queue("t5_bytes", got, want);
    want = '{8'h00, 8'h00, 8'h01};
    check_queue("t5_last", lasts, want);

    // Reset in the middle of a payload
    clear_logs();
    stim = '{8'hAA, 8'h04, 8'h01, 8'h02};
    apply_stimulus(stim);
    tick();
    RSTn = 1'b0;
    #2;
    check_reset_values("midreset");
    repeat (2) tick();
    RSTn = 1'b1;
    repeat (2) tick();
`ifdef RX_FRAME_CHECKSUM_EN
    stim = '{8'hAA, 8'h02, 8'h5A, 8'hA5, 8'h01};
`else
    stim = '{8'hAA, 8'h02, 8'h5A, 8'hA5};
`endif
    apply_stimulus(stim);
    wait_idle();
    want = '{8'h5A, 8'hA5};
    check_queue("t6_bytes", got, want);
    check_queue("t6_errs", errs, none);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
